mul_wb_drain: RTL and testbench

- Drain end of the multiply pipeline (M1..M5). Accepts finished multiply results (result, zero, overflow, dst) from the last M stage and delivers them to the register-file write port.
- The ALU path has priority on that port. Results that cannot be written immediately are held in a small FIFO, and backpressure is applied to the multiply pipe via in_ready.
- Publishes a pending-destination mask for hazard detection in decode.

---
 rtl/mul_wb_drain_pkg.sv | 27 ++
 rtl/mul_drain_fifo.sv | 81 ++++++++
 rtl/mul_wb_drain.sv | 131 +++++++++++++
 tb/tb_mul_wb_drain.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_wb_drain_pkg.sv
// Shared constants and occupancy decode for the multiply write-back drain.
// Queue entries are packed as {overflow, zero, dst[4:0], result}.
package mul_wb_drain_pkg;

  localparam int MULQ_REG_SIZE = 32;
  localparam int MULQ_DEPTH    = 4;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;

  // Classify queue occupancy from the raw entry count.
  function automatic occ_state_t occ_decode(input int cnt, input int depth);
    occ_state_t occ;
    if (cnt == 0) begin
      occ = OCC_EMPTY;
    end else if (cnt >= depth) begin
      occ = OCC_FULL;
    end else begin
      occ = OCC_PARTIAL;
    end
    return occ;
  endfunction

endpackage

// File: rtl/mul_drain_fifo.sv
// Circular holding queue for multiply results waiting for the write port.
// Exposes each slot's dst and a "live" flag (valid and not an overflow entry)
// so the top can build the pending-destination mask.
module mul_drain_fifo #(
  parameter int REG_SIZE = 32,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = $clog2(DEPTH) + 1,
  parameter int ENT_W    = REG_SIZE + 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ENT_W-1:0]      wr_entry,
  output logic [ENT_W-1:0]      head_entry,
  output logic [CNT_W-1:0]      count,
  output logic [DEPTH-1:0][4:0] ent_dst,
  output logic [DEPTH-1:0]      ent_live
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ENT_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic [PTR_W-1:0] offset_s;

  // Write the incoming entry at the tail slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push && !clr) begin
      mem_r[tail_r] <= wr_entry;
    end
  end

  // Advance pointers and track occupancy; clear wins over push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (clr) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (push) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      if (pop) begin
        head_r <= head_r + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_entry = mem_r[head_r];
  assign count      = count_r;

  // Slot i is occupied when its distance from head is below the count.
  always_comb begin
    offset_s = '0;
    ent_dst  = '0;
    ent_live = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset_s    = PTR_W'(i) - head_r;
      ent_dst[i]  = mem_r[i][ENT_W-3 -: 5];
      ent_live[i] = ({1'b0, offset_s} < count_r) & ~mem_r[i][ENT_W-1];
    end
  end

endmodule

// File: rtl/mul_wb_drain.sv
// Drain end of the multiply pipe: filters finished products, bypasses or
// queues them behind the ALU on the shared register-file write port, raises
// overflow exceptions in order, and publishes pending destinations.
module mul_wb_drain
  import mul_wb_drain_pkg::*;
#(
  parameter int REG_SIZE = MULQ_REG_SIZE,
  parameter int DEPTH    = MULQ_DEPTH,
  parameter int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [REG_SIZE-1:0] in_result,
  input  logic                in_zero,
  input  logic                in_overflow,
  input  logic [4:0]          in_dst,
  output logic                in_ready,
  input  logic                alu_wb_valid,
  output logic                wb_valid,
  output logic [REG_SIZE-1:0] wb_data,
  output logic [4:0]          wb_dst,
  output logic                wb_zero,
  output logic                ovf_exc,
  output logic [4:0]          ovf_dst,
  output logic [31:0]         pending_mask,
  output logic [CNT_W-1:0]    count
);

  localparam int ENT_W = REG_SIZE + 7;

  occ_state_t          occ_s;
  logic                push_s;
  logic                keep_s;
  logic                pop_s;
  logic                bypass_s;
  logic                enq_s;
  logic                issue_s;
  logic [ENT_W-1:0]    in_entry_s;
  logic [ENT_W-1:0]    head_entry_s;
  logic [ENT_W-1:0]    issue_entry_s;
  logic [CNT_W-1:0]    count_s;
  logic [DEPTH-1:0][4:0] ent_dst_s;
  logic [DEPTH-1:0]    ent_live_s;
  logic [31:0]         mask_s;

  logic                wb_valid_r;
  logic [REG_SIZE-1:0] wb_data_r;
  logic [4:0]          wb_dst_r;
  logic                wb_zero_r;
  logic                ovf_exc_r;
  logic [4:0]          ovf_dst_r;

  assign in_entry_s = {in_overflow, in_zero, in_dst, in_result};
  assign occ_s      = occ_decode(int'(count_s), DEPTH);
  assign in_ready   = (occ_s != OCC_FULL) & ~flush & ~reset;

  // Accept filter and the pop / bypass / enqueue decision for this edge.
  always_comb begin
    push_s        = in_valid & in_ready;
    keep_s        = push_s & (in_overflow | (in_dst != 5'd0));
    pop_s         = ~alu_wb_valid & (occ_s != OCC_EMPTY) & ~flush;
    bypass_s      = ~alu_wb_valid & (occ_s == OCC_EMPTY) & keep_s & ~flush;
    enq_s         = keep_s & ~bypass_s & ~flush;
    issue_s       = pop_s | bypass_s;
    issue_entry_s = pop_s ? head_entry_s : in_entry_s;
  end

  mul_drain_fifo #(
    .REG_SIZE (REG_SIZE),
    .DEPTH    (DEPTH),
    .CNT_W    (CNT_W),
    .ENT_W    (ENT_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .clr        (flush),
    .push       (enq_s),
    .pop        (pop_s),
    .wr_entry   (in_entry_s),
    .head_entry (head_entry_s),
    .count      (count_s),
    .ent_dst    (ent_dst_s),
    .ent_live   (ent_live_s)
  );

  // Issue register: overflow entries raise the exception instead of writing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid_r <= 1'b0;
      wb_data_r  <= '0;
      wb_dst_r   <= 5'd0;
      wb_zero_r  <= 1'b0;
      ovf_exc_r  <= 1'b0;
      ovf_dst_r  <= 5'd0;
    end else if (flush) begin
      wb_valid_r <= 1'b0;
      ovf_exc_r  <= 1'b0;
    end else if (issue_s) begin
      wb_valid_r <= ~issue_entry_s[ENT_W-1];
      ovf_exc_r  <= issue_entry_s[ENT_W-1];
      wb_zero_r  <= issue_entry_s[ENT_W-2];
      wb_dst_r   <= issue_entry_s[ENT_W-3 -: 5];
      ovf_dst_r  <= issue_entry_s[ENT_W-3 -: 5];
      wb_data_r  <= issue_entry_s[REG_SIZE-1:0];
    end else begin
      wb_valid_r <= 1'b0;
      ovf_exc_r  <= 1'b0;
    end
  end

  // Decode held non-overflow destinations into the hazard mask; r0 never pends.
  always_comb begin
    mask_s = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      mask_s[ent_dst_s[i]] = mask_s[ent_dst_s[i]] | ent_live_s[i];
    end
    mask_s[0] = 1'b0;
  end

  assign wb_valid     = wb_valid_r;
  assign wb_data      = wb_data_r;
  assign wb_dst       = wb_dst_r;
  assign wb_zero      = wb_zero_r;
  assign ovf_exc      = ovf_exc_r;
  assign ovf_dst      = ovf_dst_r;
  assign pending_mask = mask_s;
  assign count        = count_s;

endmodule

// File: tb/tb_mul_wb_drain.sv
// Directed and randomized bench for mul_wb_drain against a queue-based model.
module tb_mul_wb_drain;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_result = 32'd0;
  logic        in_zero = 1'b0;
  logic        in_overflow = 1'b0;
  logic [4:0]  in_dst = 5'd0;
  logic        alu_wb_valid = 1'b0;
  logic        in_ready;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_dst;
  logic        wb_zero;
  logic        ovf_exc;
  logic [4:0]  ovf_dst;
  logic [31:0] pending_mask;
  logic [CNT_W-1:0] count;

  always #5 clk = ~clk;

  mul_wb_drain #(.REG_SIZE(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_result(in_result), .in_zero(in_zero), .in_overflow(in_overflow),
    .in_dst(in_dst), .in_ready(in_ready), .alu_wb_valid(alu_wb_valid),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_dst(wb_dst), .wb_zero(wb_zero),
    .ovf_exc(ovf_exc), .ovf_dst(ovf_dst), .pending_mask(pending_mask), .count(count)
  );

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ov;
    logic [4:0]  d;
  } ent_t;

  ent_t        q[$];
  logic        e_wb_valid = 1'b0;
  logic        e_ovf = 1'b0;
  logic [31:0] e_data = 32'd0;
  logic [4:0]  e_dst = 5'd0;
  logic        e_zero = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = 32'd0;
    foreach (q[i]) begin
      if (!q[i].ov) m[q[i].d] = 1'b1;
    end
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic check_outputs();
    chk("wb_valid", 32'(wb_valid), 32'(e_wb_valid));
    if (e_wb_valid) begin
      chk("wb_data", wb_data, e_data);
      chk("wb_dst", 32'(wb_dst), 32'(e_dst));
      chk("wb_zero", 32'(wb_zero), 32'(e_zero));
    end
    chk("ovf_exc", 32'(ovf_exc), 32'(e_ovf));
    if (e_ovf) chk("ovf_dst", 32'(ovf_dst), 32'(e_dst));
    chk("count", 32'(count), 32'(q.size()));
    chk("pending_mask", pending_mask, model_mask());
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_wb_dst"}, 32'(wb_dst), 32'd0);
    chk({tag, "_ovf_exc"}, 32'(ovf_exc), 32'd0);
    chk({tag, "_ovf_dst"}, 32'(ovf_dst), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_mask"}, pending_mask, 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  // One clock of stimulus: drive, check ready, predict, clock, compare.
  task automatic step(input logic v, input logic [31:0] res, input logic z,
                      input logic ov, input logic [4:0] d, input logic alu, input logic fl);
    logic exp_ready;
    logic keep;
    logic issue;
    ent_t e;
    ent_t inc;
    in_valid = v; in_result = res; in_zero = z; in_overflow = ov;
    in_dst = d; alu_wb_valid = alu; flush = fl;
    #1;
    exp_ready = (q.size() < DEPTH) && !fl;
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    keep = v && exp_ready && (ov || d != 5'd0);
    inc = '{res, z, ov, d};
    e = inc;
    issue = 1'b0;
    if (fl) begin
      q.delete();
    end else if (!alu) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        issue = 1'b1;
        if (keep) q.push_back(inc);
      end else if (keep) begin
        issue = 1'b1;
      end
    end else if (keep) begin
      q.push_back(inc);
    end
    if (issue) begin
      e_wb_valid = !e.ov; e_ovf = e.ov; e_data = e.res; e_dst = e.d; e_zero = e.z;
    end else begin
      e_wb_valid = 1'b0; e_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input logic alu);
    step(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, alu, 1'b0);
  endtask

  initial begin
    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("por");
    #3 reset = 1'b0;
    #1 chk("ready_after_por", 32'(in_ready), 32'd1);

    // Bypass with empty queue and free port
    step(1'b1, 32'h0000_0006, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0);
    idle(1'b0);

    // Blocked for three cycles, then drain in order
    step(1'b1, 32'h11, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0);
    step(1'b1, 32'h0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0);
    step(1'b1, 32'h33, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
    chk("blocked_mask", pending_mask, 32'h0000_000E);
    repeat (4) idle(1'b0);

    // Fill to full, hold the fifth result, then free slots
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, 1'b0, 5'(8 + i), 1'b1, 1'b0);
    chk("full_count", 32'(count), 32'd4);
    step(1'b1, 32'hABCD, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0);
    step(1'b1, 32'hABCD, 1'b0, 1'b0, 5'd12, 1'b0, 1'b0);
    step(1'b1, 32'hABCD, 1'b0, 1'b0, 5'd12, 1'b0, 1'b0);
    repeat (5) idle(1'b0);

    // Filters: r0 discarded, overflow raises exception only
    step(1'b1, 32'h55, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    step(1'b1, 32'h77, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    step(1'b1, 32'h78, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0);
    chk("ovf_not_pending", 32'(pending_mask[7]), 32'd0);
    repeat (2) idle(1'b0);

    // Flush with three held entries and a live incoming result
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0, 5'(20 + i), 1'b1, 1'b0);
    step(1'b1, 32'h99, 1'b0, 1'b0, 5'd30, 1'b0, 1'b1);
    idle(1'b0);

    // Asynchronous reset between edges with two entries held
    step(1'b1, 32'h1, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0);
    step(1'b1, 32'h2, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 check_reset_state("midrst");
    #1 reset = 1'b0;
    q.delete();
    e_wb_valid = 1'b0; e_ovf = 1'b0;
    #1 chk("ready_after_midrst", 32'(in_ready), 32'd1);
    for (int i = 0; i < 10; i++)
      step(1'b1, $urandom, 1'(i % 2), 1'b0, 5'(1 + i), 1'(i < 6), 1'b0);
    repeat (5) idle(1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(3, 0) != 0), $urandom, 1'($urandom_range(1, 0)),
           1'($urandom_range(7, 0) == 0), 5'($urandom_range(31, 0)),
           1'($urandom_range(1, 0)), 1'($urandom_range(24, 0) == 0));
    repeat (6) idle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
